// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
// Holds the FSM encoding, the x0 register index and the canned control patterns.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1
    } state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic flush_id;
        logic bubble_ex;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_IDLE = '{stall_if: 1'b0, stall_id: 1'b0, stall_ex: 1'b0,
                                       flush_id: 1'b0, bubble_ex: 1'b0};
    // NOP injection into IF/ID and ID/EX: used for reset and for wrong-path kill.
    localparam hz_ctrl_t CTRL_NOP  = '{stall_if: 1'b0, stall_id: 1'b0, stall_ex: 1'b0,
                                       flush_id: 1'b1, bubble_ex: 1'b1};
    localparam hz_ctrl_t CTRL_MEM  = '{stall_if: 1'b1, stall_id: 1'b1, stall_ex: 1'b1,
                                       flush_id: 1'b0, bubble_ex: 1'b0};
    localparam hz_ctrl_t CTRL_LU   = '{stall_if: 1'b1, stall_id: 1'b1, stall_ex: 1'b0,
                                       flush_id: 1'b0, bubble_ex: 1'b1};

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator between the ID and EX stages.
// Zero latency, no state; x0 as a destination never creates a hazard.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic [4:0] ex_rd_i,
    input  logic       ex_reg_wr_i,
    input  logic       ex_mem_to_reg_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    output logic       lu_haz_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_use_rs1_i & (id_rs1_i == ex_rd_i);
    assign rs2_hit  = id_use_rs2_i & (id_rs2_i == ex_rd_i);
    assign lu_haz_o = ex_mem_to_reg_i & ex_reg_wr_i & (ex_rd_i != REG_X0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Freeze/flush/bubble controller for the five-stage pipeline; Mealy outputs, same-cycle.
// Data-memory waits stall the whole front end until ready or MEM_TIMEOUT stalled cycles.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_RegWr,
    input  logic             ex_MemtoReg,
    input  logic             ex_branch_taken,
    input  logic             mem_MemtoReg,
    input  logic             mem_MemWr,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [7:0]       TIMEOUT = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic     mem_op;
    logic     mstall;
    logic     req;
    logic     lu_haz;
    hz_ctrl_t ctrl;

    assign mem_op = mem_MemtoReg | mem_MemWr;

    load_use_detect u_lu (
        .ex_rd_i         (ex_rd),
        .ex_reg_wr_i     (ex_RegWr),
        .ex_mem_to_reg_i (ex_MemtoReg),
        .id_rs1_i        (id_rs1),
        .id_rs2_i        (id_rs2),
        .id_use_rs1_i    (id_use_rs1),
        .id_use_rs2_i    (id_use_rs2),
        .lu_haz_o        (lu_haz)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        mstall     = 1'b0;
        req        = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                req    = mem_op;
                mstall = mem_op & ~dmem_ready;
                if (mstall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            ST_MEM_WAIT: begin
                req    = mem_op;
                mstall = ~dmem_ready & (wait_cnt_q != TIMEOUT);
                if (dmem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == TIMEOUT) begin
                    // Abandon the access; the pipeline treats it as completed.
                    state_d    = ST_RUN;
                    wait_cnt_d = 8'd0;
                    mem_err_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // A memory stall defers branch kill: the branch stays in EX and is re-seen on release.
    always_comb begin
        ctrl = CTRL_IDLE;
        if (reset) begin
            ctrl = CTRL_NOP;
        end else if (mstall) begin
            ctrl = CTRL_MEM;
        end else if (ex_branch_taken) begin
            ctrl = CTRL_NOP;
        end else if (lu_haz) begin
            ctrl = CTRL_LU;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (ctrl.stall_if && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= 8'd0;
            mem_err_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_err_q      <= mem_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign dmem_req     = req & ~reset;
    assign stall_if     = ctrl.stall_if;
    assign stall_id     = ctrl.stall_id;
    assign stall_ex     = ctrl.stall_ex;
    assign flush_id     = ctrl.flush_id;
    assign bubble_ex    = ctrl.bubble_ex;
    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_cycles_q;

endmodule
